// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one partial product per clock.
// Handshake: start (sampled in IDLE) -> busy for WIDTH cycles -> one-cycle done.
// product holds the last result until the next completion or reset.
// Optional feature macro: SEQ_MULT_SIGNED_EN (enables signed_mode handling).
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 signed_mode,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   a_ld;
  logic [WIDTH-1:0]   b_ld;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] result;
  logic               last;

`ifdef SEQ_MULT_SIGNED_EN
  logic neg_q;
  logic neg_ld;

  // Operand conditioning: magnitudes and result sign in signed mode.
  // The most negative value negates to itself, which read as unsigned is its magnitude.
  always_comb begin
    a_ld   = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    b_ld   = (signed_mode && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
    neg_ld = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
  end

  // Final result: two's-complement negate when the operand signs differed.
  always_comb begin
    result = neg_q ? -acc_nxt : acc_nxt;
  end
`else
  logic unused_signed_mode;
  assign unused_signed_mode = signed_mode;

  // Operand conditioning: plain unsigned operands.
  always_comb begin
    a_ld = multiplicand;
    b_ld = multiplier;
  end

  // Final result: accumulator as-is.
  always_comb begin
    result = acc_nxt;
  end
`endif

  // One shift-add step: add A into the upper half (carry kept), then shift {carry, acc} right.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    acc_nxt = {sum, acc[WIDTH-1:1]};
    last    = (cnt == CW'(WIDTH - 1));
  end

  // Control FSM and datapath registers; synchronous reset aborts any operation.
  always_ff @(posedge clk) begin
    if (areset) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= a_ld;
            b_q   <= b_ld;
            acc   <= '0;
            cnt   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q <= neg_ld;
`endif
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          b_q <= b_q >> 1;
          cnt <= cnt + CW'(1);
          if (last) begin
            product <= result;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Testbench for seq_multiplier: WIDTH=8 and WIDTH=16 instances checked
// cycle by cycle against an arithmetic reference model.
module tb_seq_multiplier;

`ifdef SEQ_MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset;
  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        start16, sm16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last8 = '0;
  logic [31:0] last16 = '0;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .areset(areset), .start(start8), .multiplicand(a8),
    .multiplier(b8), .signed_mode(sm8), .busy(busy8), .done(done8), .product(p8)
  );

  seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .areset(areset), .start(start16), .multiplicand(a16),
    .multiplier(b16), .signed_mode(sm16), .busy(busy16), .done(done16), .product(p16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [15:0] a, input logic [15:0] b,
                       input logic sm);
    if (w == 8) begin
      start8 = st; a8 = a[7:0]; b8 = b[7:0]; sm8 = sm;
    end else begin
      start16 = st; a16 = a; b16 = b; sm16 = sm;
    end
  endtask

  function automatic logic [31:0] prod_of(input int w);
    return (w == 8) ? {16'h0, p8} : p16;
  endfunction

  function automatic logic [31:0] busy_of(input int w);
    return (w == 8) ? {31'h0, busy8} : {31'h0, busy16};
  endfunction

  function automatic logic [31:0] done_of(input int w);
    return (w == 8) ? {31'h0, done8} : {31'h0, done16};
  endfunction

  // Reference: integer product of the operands, interpreted as two's complement when signed.
  function automatic logic [31:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic sm);
    longint m, ai, bi, r;
    m  = longint'(1) << w;
    ai = longint'(a) & (m - 1);
    bi = longint'(b) & (m - 1);
    if (SIGNED_EN && sm) begin
      if (ai >= m / 2) ai = ai - m;
      if (bi >= m / 2) bi = bi - m;
    end
    r = (ai * bi) & (m * m - 1);
    return r[31:0];
  endfunction

  // One operation: start in cycle 0, busy 1..w, done at w+1, result held at w+2.
  // ign>0 re-asserts start with different operands during that busy cycle.
  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic sm,
                        input int ign, input string tag);
    logic [31:0] exp, prev;
    exp  = model(w, a, b, sm);
    prev = (w == 8) ? last8 : last16;
    @(negedge clk);
    drive(w, 1'b1, a, b, sm);
    for (int c = 1; c <= w; c++) begin
      @(negedge clk);
      drive(w, 1'b0, a, b, sm);
      if (c == ign) drive(w, 1'b1, ~a, b + 16'd1, ~sm);
      check({tag, "/busy"}, busy_of(w), 32'd1);
      check({tag, "/done_early"}, done_of(w), 32'd0);
      check({tag, "/held"}, prod_of(w), prev);
    end
    @(negedge clk);
    drive(w, 1'b0, a, b, sm);
    check({tag, "/done"}, done_of(w), 32'd1);
    check({tag, "/busy_off"}, busy_of(w), 32'd0);
    check({tag, "/product"}, prod_of(w), exp);
    @(negedge clk);
    check({tag, "/done_pulse"}, done_of(w), 32'd0);
    check({tag, "/idle"}, busy_of(w), 32'd0);
    check({tag, "/product_held"}, prod_of(w), exp);
    if (w == 8) last8 = exp; else last16 = exp;
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rs;
    areset = 1'b1;
    drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
    drive(16, 1'b0, 16'd0, 16'd0, 1'b0);
    repeat (2) @(negedge clk);
    // Reset wins over a simultaneous start.
    drive(8, 1'b1, 16'd7, 16'd9, 1'b0);
    @(negedge clk);
    areset = 1'b0;
    drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
    check("reset/busy8", busy_of(8), 32'd0);
    check("reset/done8", done_of(8), 32'd0);
    check("reset/prod8", prod_of(8), 32'd0);
    check("reset/prod16", prod_of(16), 32'd0);
    @(negedge clk);
    check("reset/still_idle8", busy_of(8), 32'd0);

    run_op(8, 16'd13, 16'd11, 1'b0, 0, "a13b11");
    check("a13b11/const", prod_of(8), 32'd143);
    run_op(8, 16'd255, 16'd255, 1'b0, 0, "max8");
    check("max8/const", prod_of(8), 32'h0000FE01);
    run_op(8, 16'd0, 16'd200, 1'b0, 0, "zeroA");
    run_op(8, 16'd37, 16'd0, 1'b0, 0, "zeroB");
    run_op(8, 16'd99, 16'd77, 1'b0, 3, "ignore_start");
    run_op(8, 16'd6, 16'd7, 1'b0, 8, "ignore_last");

    // Mid-run reset: abort at cycle 4, everything cleared the next cycle.
    @(negedge clk);
    drive(8, 1'b1, 16'd50, 16'd60, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      drive(8, 1'b0, 16'd50, 16'd60, 1'b0);
    end
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    check("abort/prod", prod_of(8), 32'd0);
    check("abort/busy", busy_of(8), 32'd0);
    check("abort/done", done_of(8), 32'd0);
    last8  = '0;
    last16 = '0;
    run_op(8, 16'd21, 16'd3, 1'b0, 0, "after_abort");

    // Signed operand patterns (unsigned results when the signed feature is absent).
    run_op(8, 16'hFD, 16'd5, 1'b1, 0, "s_m3x5");
    run_op(8, 16'h80, 16'h80, 1'b1, 0, "s_m128sq");
    run_op(8, 16'h80, 16'h7F, 1'b1, 0, "s_m128x127");
    run_op(8, 16'hFD, 16'd5, 1'b0, 0, "u_253x5");
    check("u_253x5/const", prod_of(8), 32'd1265);
`ifdef SEQ_MULT_SIGNED_EN
    run_op(8, 16'hFD, 16'd5, 1'b1, 0, "s_m3x5b");
    check("s_m3x5/const", prod_of(8), 32'h0000FFF1);
    run_op(8, 16'h80, 16'h7F, 1'b1, 0, "s_m128x127b");
    check("s_m128x127/const", prod_of(8), 32'h0000C080);
`endif

    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      run_op(8, ra, rb, rs, 0, "rand8");
    end

    run_op(16, 16'hFFFF, 16'hFFFF, 1'b0, 0, "max16");
    check("max16/const", prod_of(16), 32'hFFFE0001);
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      run_op(16, ra, rb, rs, 0, "rand16");
    end
    run_op(16, 16'h8000, 16'h8000, 1'b1, 0, "s16_min");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier computing product = multiplicand × multiplier for WIDTH-bit operands, one partial-product iteration per clock. It is the next-generation replacement for the fixed 8×8 shift-add multiplier in the CSLab arithmetic blocks. It adds a start/busy/done handshake, a product register held stable between operations, and optional signed operation. It sits behind a simple controller that issues operands and waits for done.

## Interface
- WIDTH, 8, operand width in bits (≥2); product is 2·WIDTH bits.
- clk  in  1  rising-edge clock.
- areset  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- multiplicand  in  WIDTH  operand A; sampled on the edge that accepts start.
- multiplier  in  WIDTH  operand B; sampled on the edge that accepts start.
- signed_mode  in  1  1 = two's-complement operands; ignored unless SEQ_MULT_SIGNED_EN is defined.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse when product is updated.
- product  out  2·WIDTH  result register; holds the last result until the next completion.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE, start=1:
  - Latch A, B (magnitudes in signed mode) into internal regs.
  - Latch the result sign (signA XOR signB) in signed mode.
  - Clear the 2·WIDTH accumulator; clear the iteration counter; go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each cycle:
  - If B[0]=1: upper half of acc ← upper half + A, computed WIDTH+1 bits wide to keep the carry.
  - Then {carry, acc} shifts right 1 and B shifts right 1.
  - The counter increments.
- RUN after WIDTH iterations: load product from acc, negated (two's complement) if the sign flag is set; go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE unconditionally.
- start while in RUN or DONE is ignored: no queuing, operands not resampled.
- Width rules:
  - Unsigned: full 2·WIDTH product, no overflow possible.
  - Signed: magnitude |x| of the most negative value (e.g. −128 at WIDTH=8) is representable as WIDTH-bit unsigned. The product always fits 2·WIDTH signed.
- A zero operand still takes the full WIDTH iterations; no early termination.
- areset mid-operation:
  - Abort; the next state is IDLE.
  - product, busy and done are cleared; the in-flight result is lost.

## Timing
- Reset values: product=0, busy=0, done=0, state IDLE, counter 0.
- Cycle 0: start high, sampled at its closing edge.
- busy high cycles 1..WIDTH.
- product updated at the closing edge of cycle WIDTH; done high in cycle WIDTH+1.
- Latency start→done = WIDTH+1 cycles.
- Earliest next accepted start is in cycle WIDTH+2. Throughput is one result per WIDTH+2 cycles.
- product does not change in any cycle other than the first cycle of done, or reset.
- areset has priority over start in the same cycle.

## Configuration
- SEQ_MULT_SIGNED_EN defined:
  - signed_mode selects two's-complement handling: abs on load, sign flag, negate on completion.
  - Timing is identical to unsigned mode.
- SEQ_MULT_SIGNED_EN undefined:
  - signed_mode port remains but is ignored; operands are always unsigned.
  - No abs/negate logic is synthesised.

## Test plan
- WIDTH=8, A=13, B=11, start one cycle → busy cycles 1–8, done cycle 9, product=143, held until the next start.
- WIDTH=8, A=255, B=255 → product=65025 (0xFE01); A=0, B=200 → product=0, still 9-cycle latency.
- WIDTH=8, start re-asserted during busy with different operands → ignored; first result correct; no second done.
- WIDTH=8, areset at cycle 4 of a run → product=0, busy=0, done=0 next cycle; a fresh start then completes correctly.
- SEQ_MULT_SIGNED_EN defined, WIDTH=8, signed_mode=1:
  - −3×5 → 0xFFF1
  - −128×−128 → 16384
  - −128×127 → −16256 (0xC080)
  - same operands with signed_mode=0 → unsigned results (253×5 = 1265)
- WIDTH=16, A=B=0xFFFF, unsigned → product=0xFFFE0001, done at cycle 17.
